alu_pipe: RTL and testbench

- Parametrised, handshaked successor to the 32-bit combinational ALU, with WIDTH generalised.
- Keeps the eight-op command set, with the same encodings and flag semantics.
- Adds shifts and an iterative shift-add multiply.
- Registers results behind a valid/ready interface, so the datapath sequencer can issue operations and apply backpressure.

---
 rtl/alu_pipe.sv | 174 +++++++++++++++++
 tb/tb_alu_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Pipelined, handshaked ALU: single-cycle arithmetic/logic/shift ops plus an
// optional iterative shift-add multiply enabled by the ALU_PIPE_MUL_EN macro.
module alu_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       command,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             err
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] CMD_ADD  = 4'd0;
  localparam logic [3:0] CMD_SUB  = 4'd1;
  localparam logic [3:0] CMD_XOR  = 4'd2;
  localparam logic [3:0] CMD_SLT  = 4'd3;
  localparam logic [3:0] CMD_AND  = 4'd4;
  localparam logic [3:0] CMD_NAND = 4'd5;
  localparam logic [3:0] CMD_NOR  = 4'd6;
  localparam logic [3:0] CMD_OR   = 4'd7;
  localparam logic [3:0] CMD_SLL  = 4'd9;
  localparam logic [3:0] CMD_SRL  = 4'd10;
  localparam logic [3:0] CMD_SRA  = 4'd11;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic               w_ov_add;
  logic               w_ov_sub;
  logic               w_lt;
  logic [SHW-1:0]     w_amt;
  logic [WIDTH-1:0]   w_res;
  logic               w_co;
  logic               w_ov;
  logic               w_err;
  logic               w_accept;

  // Subtraction as A + ~B + 1 so the carry out doubles as "no borrow".
  assign w_sum    = {1'b0, op_a} + {1'b0, op_b};
  assign w_diff   = {1'b0, op_a} + {1'b0, ~op_b} + (WIDTH+1)'(1);
  assign w_ov_add = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (w_sum[WIDTH-1] != op_a[WIDTH-1]);
  assign w_ov_sub = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (w_diff[WIDTH-1] != op_a[WIDTH-1]);
  // Sign of the difference corrected by overflow gives a true signed compare.
  assign w_lt     = w_diff[WIDTH-1] ^ w_ov_sub;
  assign w_amt    = op_b[SHW-1:0];

`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0]  CMD_MUL = 4'd8;
  localparam int unsigned CNTW    = SHW + 1;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_mplier;
  logic [CNTW-1:0]      r_cnt;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic                 w_is_mul;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign in_ready   = (r_state == ST_IDLE) && (!out_valid || out_ready);
`else
  assign in_ready   = !out_valid || out_ready;
`endif

  assign w_accept = in_valid && in_ready;

  // Single-cycle result and flag selection.
  always_comb begin
    w_res = '0;
    w_co  = 1'b0;
    w_ov  = 1'b0;
    w_err = 1'b0;
`ifdef ALU_PIPE_MUL_EN
    w_is_mul = 1'b0;
`endif
    case (command)
      CMD_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_co  = w_sum[WIDTH];
        w_ov  = w_ov_add;
      end
      CMD_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_co  = w_diff[WIDTH];
        w_ov  = w_ov_sub;
      end
      CMD_XOR:  w_res = op_a ^ op_b;
      CMD_SLT:  w_res = WIDTH'(w_lt);
      CMD_AND:  w_res = op_a & op_b;
      CMD_NAND: w_res = ~(op_a & op_b);
      CMD_NOR:  w_res = ~(op_a | op_b);
      CMD_OR:   w_res = op_a | op_b;
`ifdef ALU_PIPE_MUL_EN
      CMD_MUL:  w_is_mul = 1'b1;
`endif
      CMD_SLL:  w_res = op_a << w_amt;
      CMD_SRL:  w_res = op_a >> w_amt;
      CMD_SRA:  w_res = WIDTH'($signed(op_a) >>> w_amt);
      default:  w_err = 1'b1;
    endcase
  end

  // Output register, handshake and multiply sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      carryout  <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      err       <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      r_state   <= ST_IDLE;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
`endif
    end else begin
      if (w_accept) begin
`ifdef ALU_PIPE_MUL_EN
        if (w_is_mul) begin
          r_state   <= ST_MUL;
          r_mcand   <= {{WIDTH{1'b0}}, op_a};
          r_mplier  <= op_b;
          r_acc     <= '0;
          r_cnt     <= CNTW'(WIDTH);
          out_valid <= 1'b0;
        end else
`endif
        begin
          out_valid <= 1'b1;
          result    <= w_res;
          carryout  <= w_co;
          overflow  <= w_ov;
          zero      <= (w_res == '0);
          err       <= w_err;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
`ifdef ALU_PIPE_MUL_EN
      if (r_state == ST_MUL) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CNTW'(1);
        if (r_cnt == CNTW'(1)) begin
          r_state   <= ST_IDLE;
          out_valid <= 1'b1;
          result    <= w_acc_next[WIDTH-1:0];
          carryout  <= 1'b0;
          overflow  <= |w_acc_next[2*WIDTH-1:WIDTH];
          zero      <= (w_acc_next[WIDTH-1:0] == '0);
          err       <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=32); multiply checks run
// when ALU_PIPE_MUL_EN is defined, otherwise command 8 is checked as illegal.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  command;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carryout;
  logic        overflow;
  logic        zero;
  logic        err;

  int total = 0;
  int bad   = 0;

  alu_pipe #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .command(command), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carryout(carryout),
    .overflow(overflow), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] res,
                           input logic co, input logic ov, input logic z, input logic e);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_result"}, result, res);
    check({tag, "_flags"}, {28'd0, carryout, overflow, zero, err}, {28'd0, co, ov, z, e});
  endtask

  // Offers an op and advances one edge; in_valid stays high for back-to-back use.
  task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    command  = cmd;
    op_a     = a;
    op_b     = b;
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int busy;
    int seen;
    logic [31:0] held;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op_a = '0; op_b = '0; command = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {28'd0, carryout, overflow, zero, err}, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Arithmetic
    issue(4'd0, 32'(-2147483000), 32'd483001);
    check_out("add", 32'h80076141, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd1, 32'd2147483000, 32'd483001);
    check_out("sub", 32'h7FF89EBF, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(4'd0, 32'h7FFFFFFF, 32'd1);
    check_out("add_ov", 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0);

    // Logic ops back-to-back
    issue(4'd4, 32'hAAAAF0F0, 32'h55550FF0);
    check_out("and", 32'h000000F0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd5, 32'hAAAAF0F0, 32'h55550FF0);
    check_out("nand", 32'hFFFFFF0F, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd7, 32'hAAAAF0F0, 32'h55550FF0);
    check_out("or", 32'hFFFFFFF0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd6, 32'hAAAAF0F0, 32'h55550FF0);
    check_out("nor", 32'h0000000F, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd2, 32'hAAAAF0F0, 32'h55550FF0);
    check_out("xor", 32'hFFFFFF00, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd3, 32'(-2147483000), 32'd483001);
    check_out("slt_t", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd3, 32'd2147483000, 32'd483001);
    check_out("slt_f", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(4'd3, 32'h7FFFFFFF, 32'h80000000);
    check_out("slt_ovf", 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(4'd13, 32'h12345678, 32'h9ABCDEF0);
    check_out("illegal13", 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Shifts, amount taken modulo 32
    issue(4'd9, 32'h80000001, 32'd4);
    check_out("sll", 32'h00000010, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd10, 32'h80000001, 32'd4);
    check_out("srl", 32'h08000000, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd11, 32'h80000001, 32'd4);
    check_out("sra", 32'hF8000000, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd9, 32'h80000001, 32'd36);
    check_out("sll36", 32'h00000010, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd11, 32'h80000001, 32'd36);
    check_out("sra36", 32'hF8000000, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();
    check("drain_no_new", 32'(out_valid), 32'd0);

`ifdef ALU_PIPE_MUL_EN
    issue(4'd8, 32'h00010000, 32'h00010000);
    in_valid = 1'b0;
    n = 0; busy = 0;
    while (!out_valid && n < 100) begin
      if (!in_ready) busy++;
      tick();
      n++;
    end
    check("mul_latency", 32'(n), 32'd32);
    check("mul_busy", 32'(busy), 32'd32);
    check_out("mul_ov", 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    issue(4'd8, 32'd1234, 32'd5678);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check("mul2_latency", 32'(n), 32'd32);
    check_out("mul2", 32'd7006652, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
`else
    issue(4'd8, 32'd1234, 32'd5678);
    check_out("cmd8_illegal", 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("cmd8_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    tick();
`endif

    // Backpressure: hold, then drain and refill in the same edge
    out_ready = 1'b0;
    issue(4'd0, 32'd5, 32'd7);
    check_out("bp_first", 32'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(4'd1, 32'd100, 32'd1);
    held = {28'd0, carryout, overflow, zero, err};
    for (int i = 0; i < 5; i++) begin
      check("hold_result", result, 32'd12);
      check("hold_flags", {28'd0, carryout, overflow, zero, err}, held);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_valid", 32'(out_valid), 32'd1);
      command = 4'd2;
      op_a    = 32'(i);
      tick();
      command = 4'd1;
      op_a    = 32'd100;
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    check_out("refill", 32'd99, 1'b1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();
    check("refill_drained", 32'(out_valid), 32'd0);

    // Reset while a result is held
    out_ready = 1'b0;
    issue(4'd0, 32'd1, 32'd1);
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    check("rst_hold_valid", 32'(out_valid), 32'd0);
    check("rst_hold_result", result, 32'd0);

`ifdef ALU_PIPE_MUL_EN
    // Reset in the middle of a multiply aborts it silently
    issue(4'd8, 32'd1234, 32'd5678);
    in_valid = 1'b0;
    repeat (9) tick();
    check("mid_mul_busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mul_rst_valid", 32'(out_valid), 32'd0);
    check("mul_rst_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("mul_rst_no_result", 32'(seen), 32'd0);
`else
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("rst_quiet", 32'(seen), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
